// File: rtl/pipeline_ctrl_pkg.sv
// ============================================================================
// pipeline_ctrl_pkg : shared types for the MINAv2 pipeline stall/flush sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package pipeline_ctrl_pkg;

    localparam int PIPE_STAGES = 5;

    // Stall mask bit order: [0]=IA, [1]=IF/ID, [2]=ID/EX, [3]=EX/MEM, [4]=MEM/WB
    localparam logic [PIPE_STAGES-1:0] STALL_NONE  = 5'b00000;
    localparam logic [PIPE_STAGES-1:0] STALL_IA    = 5'b00001;
    localparam logic [PIPE_STAGES-1:0] STALL_FRONT = 5'b00011;
    localparam logic [PIPE_STAGES-1:0] STALL_ALL   = 5'b11111;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DWAIT = 2'd2,
        HALT  = 2'd3
    } pipe_state_e;

    typedef struct packed {
        logic stall_ia;
        logic stall_if_id;
        logic flush_if_id;
        logic stall_id_ex;
        logic flush_id_ex;
        logic stall_ex_mem;
        logic stall_mem_wb;
    } pipe_ctrl_t;

    function automatic pipe_ctrl_t make_ctrl(input logic [PIPE_STAGES-1:0] stalls,
                                             input logic fl_if_id,
                                             input logic fl_id_ex);
        pipe_ctrl_t c;
        c.stall_ia     = stalls[0];
        c.stall_if_id  = stalls[1];
        c.stall_id_ex  = stalls[2];
        c.stall_ex_mem = stalls[3];
        c.stall_mem_wb = stalls[4];
        c.flush_if_id  = fl_if_id;
        c.flush_id_ex  = fl_id_ex;
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_ctrl_perf_cnt.sv
// ============================================================================
// pipe_perf_cnt : single saturating event counter, cleared by reset
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_perf_cnt
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// ============================================================================
// pipeline_ctrl : stall/flush sequencer for the 5-stage MINAv2 pipeline with a
//                 dmem wait watchdog. Define PIPE_PERF_EN to add perf counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int DMEM_TIMEOUT = 64,
    parameter int CNT_W        = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_hazard,
    input  logic branch_taken,
    input  logic imem_ack,
    input  logic dmem_req,
    input  logic dmem_ack,
    input  logic halt_req,
    input  logic resume,
    output logic stall_ia,
    output logic stall_if_id,
    output logic flush_if_id,
    output logic stall_id_ex,
    output logic flush_id_ex,
    output logic stall_ex_mem,
    output logic stall_mem_wb,
    output logic halted,
    output logic bus_error
`ifdef PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt,
    output logic [CNT_W-1:0] perf_dwait_cnt
`endif
);

    localparam int              WAIT_W    = $clog2(DMEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DMEM_TIMEOUT - 1);

    pipe_state_e       state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    pipe_ctrl_t        ctrl;
    logic              dmem_stall;
    logic              wait_done;

    assign dmem_stall = dmem_req & ~dmem_ack;
    assign wait_done  = (wait_cnt_q == WAIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (dmem_stall) begin
                    state_d    = DWAIT;
                    wait_cnt_d = '0;
                end else if (halt_req) begin
                    state_d = HALT;
                end
            end
            DWAIT: begin
                // Ack and timeout both return to RUN; the counter stops at terminal count.
                if (dmem_ack || wait_done) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            HALT: begin
                if (resume && !halt_req) begin
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        ctrl      = make_ctrl(STALL_NONE, 1'b0, 1'b0);
        halted    = 1'b0;
        bus_error = 1'b0;
        if (!rst_n) begin
            ctrl = make_ctrl(STALL_ALL, 1'b1, 1'b1);
        end else begin
            case (state_q)
                BOOT: ctrl = make_ctrl(STALL_IA, 1'b1, 1'b1);
                RUN: begin
                    if (dmem_stall)         ctrl = make_ctrl(STALL_ALL, 1'b0, 1'b0);
                    else if (branch_taken)  ctrl = make_ctrl(STALL_NONE, 1'b1, 1'b1);
                    else if (load_hazard)   ctrl = make_ctrl(STALL_FRONT, 1'b0, 1'b1);
                    else if (!imem_ack)     ctrl = make_ctrl(STALL_IA, 1'b1, 1'b0);
                end
                DWAIT: begin
                    if (dmem_ack) begin
                        ctrl = make_ctrl(STALL_NONE, 1'b0, 1'b0);
                    end else if (wait_done) begin
                        ctrl      = make_ctrl(STALL_ALL, 1'b1, 1'b1);
                        bus_error = 1'b1;
                    end else begin
                        ctrl = make_ctrl(STALL_ALL, 1'b0, 1'b0);
                    end
                end
                HALT: begin
                    ctrl   = make_ctrl(STALL_ALL, 1'b0, 1'b0);
                    halted = 1'b1;
                end
                default: ctrl = make_ctrl(STALL_NONE, 1'b0, 1'b0);
            endcase
        end
    end

    assign stall_ia     = ctrl.stall_ia;
    assign stall_if_id  = ctrl.stall_if_id;
    assign flush_if_id  = ctrl.flush_if_id;
    assign stall_id_ex  = ctrl.stall_id_ex;
    assign flush_id_ex  = ctrl.flush_id_ex;
    assign stall_ex_mem = ctrl.stall_ex_mem;
    assign stall_mem_wb = ctrl.stall_mem_wb;

`ifdef PIPE_PERF_EN
    logic flush_accept;
    logic in_dwait;

    assign flush_accept = rst_n && (state_q == RUN) && !dmem_stall && branch_taken;
    assign in_dwait     = (state_q == DWAIT);

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_ia),
        .count (perf_stall_cnt)
    );

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_accept),
        .count (perf_flush_cnt)
    );

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_dwait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (in_dwait),
        .count (perf_dwait_cnt)
    );
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ============================================================================
// tb_pipeline_ctrl : directed + randomized self-checking bench for pipeline_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_ctrl;

    localparam int TO = 8;

    // {stall_ia, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex, stall_ex_mem, stall_mem_wb, halted, bus_error}
    localparam logic [8:0] V_ZERO  = 9'b000000000;
    localparam logic [8:0] V_RST   = 9'b111111100;
    localparam logic [8:0] V_BOOT  = 9'b101010000;
    localparam logic [8:0] V_STALL = 9'b110101100;
    localparam logic [8:0] V_BR    = 9'b001010000;
    localparam logic [8:0] V_LH    = 9'b110010000;
    localparam logic [8:0] V_IM    = 9'b101000000;
    localparam logic [8:0] V_HALT  = 9'b110101110;
    localparam logic [8:0] V_TO    = 9'b111111101;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_hazard, branch_taken, imem_ack, dmem_req, dmem_ack, halt_req, resume;
    logic stall_ia, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex;
    logic stall_ex_mem, stall_mem_wb, halted, bus_error;
    logic [8:0] dut_vec;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.DMEM_TIMEOUT(TO), .CNT_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_hazard  (load_hazard),
        .branch_taken (branch_taken),
        .imem_ack     (imem_ack),
        .dmem_req     (dmem_req),
        .dmem_ack     (dmem_ack),
        .halt_req     (halt_req),
        .resume       (resume),
        .stall_ia     (stall_ia),
        .stall_if_id  (stall_if_id),
        .flush_if_id  (flush_if_id),
        .stall_id_ex  (stall_id_ex),
        .flush_id_ex  (flush_id_ex),
        .stall_ex_mem (stall_ex_mem),
        .stall_mem_wb (stall_mem_wb),
        .halted       (halted),
        .bus_error    (bus_error)
    );

    assign dut_vec = {stall_ia, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex,
                      stall_ex_mem, stall_mem_wb, halted, bus_error};

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Reference model: booting / halted / waiting flags plus a count of dmem
    // wait cycles elapsed (1 on the first waiting cycle).
    bit m_boot = 1'b1;
    bit m_halt = 1'b0;
    bit m_wait = 1'b0;
    int m_wcnt = 0;

    always @(negedge clk) begin
        logic [8:0] exp;
        exp = V_ZERO;
        if (!rst_n) begin
            exp = V_RST;
            m_boot = 1'b1; m_halt = 1'b0; m_wait = 1'b0; m_wcnt = 0;
        end else if (m_boot) begin
            exp = V_BOOT;
            m_boot = 1'b0;
        end else if (m_halt) begin
            exp = V_HALT;
            if (resume && !halt_req) m_halt = 1'b0;
        end else if (m_wait) begin
            if (dmem_ack) begin
                exp = V_ZERO;
                m_wait = 1'b0;
            end else if (m_wcnt == TO) begin
                exp = V_TO;
                m_wait = 1'b0;
            end else begin
                exp = V_STALL;
                m_wcnt = m_wcnt + 1;
            end
        end else begin
            if (dmem_req && !dmem_ack) begin
                exp = V_STALL;
                m_wait = 1'b1;
                m_wcnt = 1;
            end else begin
                if (branch_taken)     exp = V_BR;
                else if (load_hazard) exp = V_LH;
                else if (!imem_ack)   exp = V_IM;
                else                  exp = V_ZERO;
                if (halt_req) m_halt = 1'b1;
            end
        end
        check("model", dut_vec, exp);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [8:0] exp);
        #2;
        check(name, dut_vec, exp);
    endtask

    task automatic set_idle();
        load_hazard = 1'b0; branch_taken = 1'b0; imem_ack = 1'b1;
        dmem_req = 1'b0; dmem_ack = 1'b0; halt_req = 1'b0; resume = 1'b0;
    endtask

    initial begin
        set_idle();
        rst_n = 1'b0;
        repeat (2) next_cycle();
        lit("reset", V_RST);

        next_cycle(); rst_n = 1'b1;      lit("boot", V_BOOT);
        next_cycle();                     lit("boot_done", V_ZERO);
        next_cycle(); load_hazard = 1'b1; lit("load_hazard", V_LH);
        next_cycle(); load_hazard = 1'b0; lit("lh_release", V_ZERO);
        next_cycle(); load_hazard = 1'b1; branch_taken = 1'b1; lit("branch_over_lh", V_BR);
        next_cycle(); set_idle(); imem_ack = 1'b0; lit("imem_wait", V_IM);

        next_cycle(); set_idle(); dmem_req = 1'b1; lit("dmem_issue", V_STALL);
        for (int i = 0; i < 2; i++) begin
            next_cycle(); lit("dwait", V_STALL);
        end
        next_cycle(); dmem_ack = 1'b1; lit("dmem_ack", V_ZERO);
        next_cycle(); set_idle();      lit("after_ack", V_ZERO);

        next_cycle(); dmem_req = 1'b1; lit("dmem_issue_to", V_STALL);
        for (int i = 1; i < TO; i++) begin
            next_cycle(); lit("dwait_to", V_STALL);
        end
        next_cycle();             lit("timeout", V_TO);
        next_cycle(); set_idle(); lit("after_timeout", V_ZERO);

        next_cycle(); halt_req = 1'b1; lit("halt_req_cycle", V_ZERO);
        next_cycle(); halt_req = 1'b0; lit("halted", V_HALT);
        next_cycle(); halt_req = 1'b1; resume = 1'b1; lit("halt_resume_clash", V_HALT);
        next_cycle(); halt_req = 1'b0; lit("resume_cycle", V_HALT);
        next_cycle(); resume = 1'b0;   lit("resumed", V_ZERO);

        next_cycle(); dmem_req = 1'b1; lit("dmem_issue_rst", V_STALL);
        next_cycle();                  lit("dwait_rst", V_STALL);
        next_cycle(); rst_n = 1'b0;    lit("reset_mid_dwait", V_RST);
        next_cycle(); set_idle(); rst_n = 1'b1; lit("reboot", V_BOOT);
        next_cycle();                  lit("reboot_done", V_ZERO);

        for (int n = 0; n < 4000; n++) begin
            next_cycle();
            rst_n        = ($urandom_range(0, 299) != 0);
            load_hazard  = ($urandom_range(0, 99) < 20);
            branch_taken = ($urandom_range(0, 99) < 15);
            imem_ack     = ($urandom_range(0, 99) < 75);
            dmem_req     = ($urandom_range(0, 99) < 30);
            dmem_ack     = ($urandom_range(0, 99) < 30);
            halt_req     = ($urandom_range(0, 99) < 5);
            resume       = ($urandom_range(0, 99) < 30);
        end

        next_cycle(); set_idle(); rst_n = 1'b1;
        repeat (2) next_cycle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
